// File: rtl/fp_div_issue_pkg.sv
// fp_alu_pkg: shared types and constants for the divider issue stage.
// RECOVER exists only when FP_DIV_ISSUE_TIMEOUT_EN is defined.
package fp_alu_pkg;
  localparam int FP_DIV_TAG_W = 4;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP_POS_INF = 32'h7F800000;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [FP_DIV_TAG_W-1:0] tag;
  } fp_div_req_t;
  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD
`ifdef FP_DIV_ISSUE_TIMEOUT_EN
    , RECOVER
`endif
  } div_state_t;
endpackage

// File: rtl/fp_div_issue_if.sv
// fp_div_issue_if: request and result handshakes of the divider issue stage.
interface fp_div_issue_if #(parameter int TAG_W = 4);
  logic req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [TAG_W-1:0] req_tag;
  logic res_valid, res_ready;
  logic [31:0] res_z;
  logic res_ovf, res_unf, res_err;
  logic [TAG_W-1:0] res_tag;
  modport master(output req_valid, req_a, req_b, req_tag, res_ready,
                 input req_ready, res_valid, res_z, res_ovf, res_unf, res_err, res_tag);
  modport slave(input req_valid, req_a, req_b, req_tag, res_ready,
                output req_ready, res_valid, res_z, res_ovf, res_unf, res_err, res_tag);
endinterface

// File: rtl/fp_div_issue_fifo.sv
// fp_div_issue_fifo: request FIFO with wrap-bit pointers; caller never pushes when full or pops when empty.
module fp_div_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wp_q, rp_q;
  assign empty_o = wp_q == rp_q;
  assign full_o = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign dout_o = mem_q[rp_q[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_q + {{AW{1'b0}}, push_i};
      rp_q <= rp_q + {{AW{1'b0}}, pop_i};
    end
  always_ff @(posedge clk)
    if (push_i) mem_q[wp_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/fp_div_issue.sv
// fp_div_issue: queues divide requests, drives the divider start handshake and registers its result.
// Optional watchdog with divider reset and error result: define FP_DIV_ISSUE_TIMEOUT_EN.
module fp_div_issue
  import fp_alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  fp_div_issue_if.slave bus,
  output logic div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic div_rst,
  input  logic [31:0] div_z,
  input  logic div_ovf,
  input  logic div_unf,
  input  logic div_busy,
  input  logic div_done
);
  localparam int W = 64 + TAG_W;
  div_state_t state_q, state_d;
  logic full, empty, push, pop, load_div, timeout, rec;
  logic [W-1:0] head;
  logic [31:0] a_q, b_q, res_z_q;
  logic [TAG_W-1:0] tag_q, res_tag_q;
  logic res_valid_q, res_ovf_q, res_unf_q, res_err_q;
  assign push = bus.req_valid && !full;
  // Holding off while the divider is still busy (e.g. an op abandoned by our reset) keeps start legal.
  assign pop = state_q == IDLE && !empty && !res_valid_q && !div_busy;
  fp_div_issue_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .pop_i(pop),
    .din_i({bus.req_a, bus.req_b, bus.req_tag}), .dout_o(head),
    .full_o(full), .empty_o(empty)
  );
`ifdef FP_DIV_ISSUE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic waiting;
  assign waiting = state_q == WAIT_BUSY || state_q == WAIT_DONE;
  assign timeout = waiting && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign rec = state_q == RECOVER;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= waiting ? cnt_q + CW'(1) : '0;
`else
  assign timeout = 1'b0;
  assign rec = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = pop ? ISSUE : IDLE;
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: state_d = div_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE: state_d = (!div_busy && div_done) ? HOLD : WAIT_DONE;
      default:   state_d = IDLE;
    endcase
`ifdef FP_DIV_ISSUE_TIMEOUT_EN
    if (timeout) state_d = RECOVER;
`endif
  end
  assign load_div = state_q == WAIT_DONE && state_d == HOLD;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      tag_q <= '0;
    end else begin
      state_q <= state_d;
      if (pop) {a_q, b_q, tag_q} <= head;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      res_valid_q <= 1'b0;
      res_z_q <= '0;
      res_ovf_q <= 1'b0;
      res_unf_q <= 1'b0;
      res_err_q <= 1'b0;
      res_tag_q <= '0;
    end else if (load_div || rec) begin
      res_valid_q <= 1'b1;
      res_z_q <= rec ? FP_QNAN : div_z;
      res_ovf_q <= !rec && div_ovf;
      res_unf_q <= !rec && div_unf;
      res_err_q <= rec;
      res_tag_q <= tag_q;
    end else if (res_valid_q && bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  assign bus.req_ready = !full;
  assign div_start = state_q == ISSUE;
  assign div_rst = rec;
  assign div_a = a_q;
  assign div_b = b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_z = res_z_q;
  assign bus.res_ovf = res_ovf_q;
  assign bus.res_unf = res_unf_q;
  assign bus.res_err = res_err_q;
  assign bus.res_tag = res_tag_q;
endmodule

// File: tb/tb_fp_div_issue.sv
// tb_fp_div_issue: scoreboard bench with a behavioural divider stub (sticky done, busy-gated start).
// The watchdog scenario runs only when FP_DIV_ISSUE_TIMEOUT_EN is defined.
module tb_fp_div_issue;
  import fp_alu_pkg::*;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int TO = 16;
  typedef struct packed {
    logic [31:0] z;
    logic [2:0] f;
    logic [TAG_W-1:0] tag;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fp_div_issue_if #(.TAG_W(TAG_W)) bus();
  logic div_start, div_rst;
  logic [31:0] div_a, div_b;
  logic [31:0] div_z = '0;
  logic div_ovf = 1'b0, div_unf = 1'b0, div_busy = 1'b0, div_done = 1'b0;
  int n_chk = 0, n_err = 0, n_start = 0, n_rst = 0, n_res = 0, n_sb_viol = 0;
  int lat = 6, dcnt = 0;
  bit hang = 1'b0;
  exp_t sb[$];
  fp_div_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_rst(div_rst),
    .div_z(div_z), .div_ovf(div_ovf), .div_unf(div_unf),
    .div_busy(div_busy), .div_done(div_done)
  );
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  // Quotients of the operand pairs the bench uses; {z, ovf, unf}.
  function automatic logic [33:0] div_ref(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h3F800000) return {a, 2'b00};
    if (b == 32'h0) return {FP_POS_INF, 2'b00};
    if (a == 32'h40C00000 && b == 32'h40000000) return {32'h40400000, 2'b00};
    if (a == 32'h41000000 && b == 32'h40000000) return {32'h40800000, 2'b00};
    if (a == 32'h7F000000 && b == 32'h3E800000) return {FP_POS_INF, 2'b10};
    if (a == 32'h00800000 && b == 32'h41000000) return {32'h00100000, 2'b01};
    return {FP_QNAN, 2'b00};
  endfunction
  always @(posedge clk) begin
    if (div_rst) begin
      div_busy <= 1'b0;
      div_done <= 1'b0;
    end else if (div_start && !div_busy) begin
      div_busy <= 1'b1;
      div_done <= 1'b0;
      dcnt <= lat;
    end else if (div_busy && !hang) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin
        div_busy <= 1'b0;
        div_done <= 1'b1;
        {div_z, div_ovf, div_unf} <= div_ref(div_a, div_b);
      end
    end
  end
  always @(negedge clk) begin
    if (div_start) n_start++;
    if (div_start && div_busy) n_sb_viol++;
    if (div_rst) n_rst++;
    if (!rst && bus.res_valid && bus.res_ready) begin
      n_res++;
      if (sb.size() == 0) check("unexpected_result", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("res_z", bus.res_z, e.z);
        check("res_flags", {bus.res_ovf, bus.res_unf, bus.res_err}, e.f);
        check("res_tag", bus.res_tag, e.tag);
      end
    end
  end
  task automatic send(input fp_div_req_t r, input logic [31:0] ez, input logic [2:0] ef);
    int w;
    w = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_a = r.a;
    bus.req_b = r.b;
    bus.req_tag = r.tag;
    while (!bus.req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready) begin
      check("send_timeout", 0, 1);
      bus.req_valid = 1'b0;
      return;
    end
    sb.push_back('{z: ez, f: ef, tag: r.tag});
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask
  task automatic wait_empty(input int budget);
    int w;
    w = 0;
    while (sb.size() != 0 && w < budget) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask
  initial begin
    int s0, r0, w, chg;
    logic [31:0] z0, pw;
    bus.req_valid = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_tag = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_div_start", div_start, 0);
    check("rst_div_rst", div_rst, 0);
    check("rst_res_payload", {bus.res_z, bus.res_tag, bus.res_err}, 0);
    check("rst_div_ab", {div_a, div_b}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1 bus.res_ready = 1'b1;
    send('{32'h40C00000, 32'h40000000, 4'd3}, 32'h40400000, 3'b000);
    @(negedge clk) check("lat_n1_start", div_start, 0);
    @(negedge clk) check("lat_n2_start", div_start, 1);
    @(negedge clk) check("lat_n3_start", div_start, 0);
    check("lat_n3_busy", div_busy, 1);
    wait_empty(100);
    s0 = n_start;
    send('{32'h3F800000, 32'h00000000, 4'd1}, 32'h7F800000, 3'b000);
    wait_empty(100);
    check("dz_start_pulses", n_start - s0, 1);
    send('{32'h7F000000, 32'h3E800000, 4'd2}, 32'h7F800000, 3'b100);
    send('{32'h00800000, 32'h41000000, 4'd5}, 32'h00100000, 3'b010);
    wait_empty(200);
    for (int i = 0; i <= DEPTH; i++) begin
      pw = 32'h3F800000 + (i << 23);
      send('{pw, 32'h3F800000, 4'(i)}, pw, 3'b000);
    end
    @(negedge clk) check("full_req_ready", bus.req_ready, 0);
    wait_empty(400);
    check("drained_req_ready", bus.req_ready, 1);
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    s0 = n_start;
    send('{32'h42800000, 32'h3F800000, 4'd6}, 32'h42800000, 3'b000);
    send('{32'h43000000, 32'h3F800000, 4'd7}, 32'h43000000, 3'b000);
    w = 0;
    while (!bus.res_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("bp_res_valid", bus.res_valid, 1);
    z0 = bus.res_z;
    chg = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.res_z != z0) chg++;
    end
    check("bp_z_stable", chg, 0);
    check("bp_single_start", n_start - s0, 1);
    @(posedge clk);
    #1 bus.res_ready = 1'b1;
    wait_empty(200);
    check("bp_second_start", n_start - s0, 2);
    lat = 20;
    send('{32'h40C00000, 32'h3F800000, 4'd9}, 32'h40C00000, 3'b000);
    w = 0;
    while (!div_busy && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("midrst_busy_seen", div_busy, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 check("midrst_start_low", div_start, 0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("midrst_res_valid", bus.res_valid, 0);
    lat = 6;
    r0 = n_res;
    send('{32'h41000000, 32'h40000000, 4'd8}, 32'h40800000, 3'b000);
    wait_empty(200);
    repeat (30) @(negedge clk);
    check("midrst_result_count", n_res - r0, 1);
`ifdef FP_DIV_ISSUE_TIMEOUT_EN
    hang = 1'b1;
    s0 = n_rst;
    send('{32'h3F800000, 32'h40000000, 4'd7}, FP_QNAN, 3'b001);
    wait_empty(200);
    check("wd_div_rst_pulse", n_rst - s0, 1);
    hang = 1'b0;
`endif
    check("start_while_busy", n_sb_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
